// File: rtl/pic_pkg.sv
// Shared types and constants for the parametrised interrupt controller core.
package pic_pkg;

  // Init / handshake sequencer states.
  typedef enum logic [2:0] {
    UNINIT    = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW4 = 3'd2,
    READY     = 3'd3,
    ACK1      = 3'd4
  } state_t;

  // Register map.
  localparam logic [1:0] ADDR_ICW1 = 2'd0;
  localparam logic [1:0] ADDR_DATA = 2'd1;
  localparam logic [1:0] ADDR_OCW2 = 2'd2;
  localparam logic [1:0] ADDR_OCW3 = 2'd3;

  // OCW2 command codes, {R, SL, EOI}.
  localparam logic [2:0] CMD_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] CMD_NS_EOI       = 3'b001;
  localparam logic [2:0] CMD_NOP          = 3'b010;
  localparam logic [2:0] CMD_S_EOI        = 3'b011;
  localparam logic [2:0] CMD_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] CMD_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] CMD_SET_PRIO     = 3'b110;
  localparam logic [2:0] CMD_ROT_S_EOI    = 3'b111;

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating find-first: the level just above the lowest-priority pointer wins.
module pic_priority_resolver #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               valid,
  output logic [ID_W-1:0]    level
);

  logic [ID_W-1:0] idx;

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    valid = 1'b0;
    level = '0;
    idx   = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      idx = ptr + ID_W'(k + 1);
      if (req[idx]) begin
        valid = 1'b1;
        level = idx;
      end
    end
  end

endmodule

// File: rtl/pic_core_param.sv
// N-channel interrupt controller core: init sequence, IRR/ISR/IMR,
// rotating priority and two-pulse INTA handshake.
module pic_core_param
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [1:0]         addr,
  input  logic [NUM_IRQ-1:0] wr_data,
  output logic [NUM_IRQ-1:0] rd_data,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               inta,
  output logic               int_out,
  output logic [7:0]         vector_out,
  output logic               vector_valid
);

  localparam int BASE_W = 8 - ID_W;
  localparam logic [ID_W-1:0] LOWEST = ID_W'(NUM_IRQ - 1);

  state_t              state;
  logic [NUM_IRQ-1:0]  irr, isr, imr, prev_irq;
  logic [ID_W-1:0]     ptr, win;
  logic                spurious, ltim, ic4, aeoi, rot_aeoi, read_isr;
  logic [BASE_W-1:0]   base;

  logic [NUM_IRQ-1:0]  req_vec;
  logic                req_valid, isr_valid;
  logic [ID_W-1:0]     req_level, isr_level, req_rank, isr_rank;

  assign req_vec = irr & ~imr;

  pic_priority_resolver #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_req_res (
    .req   (req_vec),
    .ptr   (ptr),
    .valid (req_valid),
    .level (req_level)
  );

  pic_priority_resolver #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_isr_res (
    .req   (isr),
    .ptr   (ptr),
    .valid (isr_valid),
    .level (isr_level)
  );

  // Rank 0 is highest priority; both ranks share the same rotation offset.
  assign req_rank = req_level - ptr - ID_W'(1);
  assign isr_rank = isr_level - ptr - ID_W'(1);

  logic            icw1_wr, active, inta1, inta2, ocw2_wr, outranks;
  logic [2:0]      cmd;
  logic [ID_W-1:0] lvl;

  assign icw1_wr  = wr_en && (addr == ADDR_ICW1);
  assign active   = (state == READY) || (state == ACK1);
  assign inta1    = inta && (state == READY) && !icw1_wr;
  assign inta2    = inta && (state == ACK1) && !icw1_wr;
  assign ocw2_wr  = wr_en && (addr == ADDR_OCW2) && active;
  assign cmd      = wr_data[7:5];
  assign lvl      = wr_data[ID_W-1:0];
  // Fully nested: only a request strictly above the highest in-service level interrupts.
  assign outranks = req_valid && (!isr_valid || (req_rank < isr_rank));

  logic [NUM_IRQ-1:0] isr_set, isr_clr, irr_clr, irr_next;
  logic [ID_W-1:0]    ptr_next;
  logic               rot_aeoi_next;

  // Gather ISR/IRR set-clear masks and pointer moves from INTA and OCW2.
  always_comb begin
    isr_set       = '0;
    isr_clr       = '0;
    irr_clr       = '0;
    ptr_next      = ptr;
    rot_aeoi_next = rot_aeoi;
    if (inta1 && req_valid) begin
      isr_set[req_level] = 1'b1;
      if (!ltim) irr_clr[req_level] = 1'b1;
    end
    if (inta2 && aeoi && !spurious) begin
      isr_clr[win] = 1'b1;
      if (rot_aeoi) ptr_next = win;
    end
    if (ocw2_wr) begin
      case (cmd)
        CMD_NS_EOI:       if (isr_valid) isr_clr[isr_level] = 1'b1;
        CMD_ROT_NS_EOI:   if (isr_valid) begin
                            isr_clr[isr_level] = 1'b1;
                            ptr_next           = isr_level;
                          end
        CMD_S_EOI:        isr_clr[lvl] = 1'b1;
        CMD_ROT_S_EOI:    begin
                            isr_clr[lvl] = 1'b1;
                            ptr_next     = lvl;
                          end
        CMD_SET_PRIO:     ptr_next = lvl;
        CMD_ROT_AEOI_SET: rot_aeoi_next = 1'b1;
        CMD_ROT_AEOI_CLR: rot_aeoi_next = 1'b0;
        CMD_NOP:          ;
        default:          ;
      endcase
    end
    // A new edge on a bit being acknowledged wins over the clear.
    irr_next = ltim ? irq : ((irr & ~irr_clr) | (irq & ~prev_irq));
  end

  // Registers, init sequencer and INTA handshake.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state        <= UNINIT;
      irr          <= '0;
      isr          <= '0;
      imr          <= '0;
      prev_irq     <= '0;
      ptr          <= LOWEST;
      win          <= '0;
      spurious     <= 1'b0;
      ltim         <= 1'b0;
      ic4          <= 1'b0;
      aeoi         <= 1'b0;
      rot_aeoi     <= 1'b0;
      read_isr     <= 1'b0;
      base         <= '0;
      rd_data      <= '0;
      int_out      <= 1'b0;
      vector_out   <= '0;
      vector_valid <= 1'b0;
    end else begin
      prev_irq     <= irq;
      vector_valid <= 1'b0;
      if (rd_en) begin
        case (addr)
          ADDR_DATA: rd_data <= imr;
          ADDR_ICW1: rd_data <= read_isr ? isr : irr;
          default:   rd_data <= '0;
        endcase
      end
      if (icw1_wr) begin
        imr     <= '0;
        isr     <= '0;
        irr     <= '0;
        ptr     <= LOWEST;
        ltim    <= wr_data[3];
        ic4     <= wr_data[0];
        int_out <= 1'b0;
        state   <= WAIT_ICW2;
      end else begin
        irr      <= irr_next;
        isr      <= (isr & ~isr_clr) | isr_set;
        ptr      <= ptr_next;
        rot_aeoi <= rot_aeoi_next;
        int_out  <= active && !inta1 && outranks;
        if (active && wr_en && (addr == ADDR_DATA)) imr <= wr_data;
        if (active && wr_en && (addr == ADDR_OCW3) && wr_data[1]) read_isr <= wr_data[0];
        case (state)
          WAIT_ICW2: if (wr_en && (addr == ADDR_DATA)) begin
                       base <= wr_data[7:ID_W];
                       if (ic4) begin
                         state <= WAIT_ICW4;
                       end else begin
                         aeoi  <= 1'b0;
                         state <= READY;
                       end
                     end
          WAIT_ICW4: if (wr_en && (addr == ADDR_DATA)) begin
                       aeoi  <= wr_data[1];
                       state <= READY;
                     end
          READY:     if (inta1) begin
                       win      <= req_valid ? req_level : LOWEST;
                       spurious <= !req_valid;
                       state    <= ACK1;
                     end
          ACK1:      if (inta2) begin
                       vector_out   <= {base, win};
                       vector_valid <= 1'b1;
                       state        <= READY;
                     end
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pic_core_param.sv
// Bench for pic_core_param: directed scenarios plus randomized traffic, all
// checked every cycle against a behavioural model of the controller.
module tb_pic_core_param;

  localparam int N  = 8;
  localparam int ID = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         wr_en = 1'b0, rd_en = 1'b0, inta = 1'b0;
  logic [1:0]   addr = '0;
  logic [N-1:0] wr_data = '0, irq = '0, rd_data;
  logic         int_out, vector_valid;
  logic [7:0]   vector_out;

  logic         wr_en16 = 1'b0, rd_en16 = 1'b0, inta16 = 1'b0;
  logic [1:0]   addr16 = '0;
  logic [15:0]  wr_data16 = '0, irq16 = '0, rd_data16;
  logic         int_out16, vector_valid16;
  logic [7:0]   vector_out16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pic_core_param #(.NUM_IRQ(8)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .irq(irq), .inta(inta),
    .int_out(int_out), .vector_out(vector_out), .vector_valid(vector_valid)
  );

  pic_core_param #(.NUM_IRQ(16)) dut16 (
    .clk(clk), .reset(reset), .wr_en(wr_en16), .rd_en(rd_en16), .addr(addr16),
    .wr_data(wr_data16), .rd_data(rd_data16), .irq(irq16), .inta(inta16),
    .int_out(int_out16), .vector_out(vector_out16), .vector_valid(vector_valid16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model (8 channels) ----------------
  bit [N-1:0] m_irr, m_isr, m_imr, m_prev;
  int         m_ptr, m_win, m_base;
  bit         m_spur, m_ltim, m_ic4, m_aeoi, m_rot, m_rdisr, m_ack;
  int         m_step;  // 0 unprogrammed, 1 expects ICW2, 2 expects ICW4, 3 operational
  bit         e_int, e_vv;
  bit [7:0]   e_vec;
  bit [N-1:0] e_rd;

  function automatic int rank_of(int p, int ptr);
    return (p - ptr - 1 + 2 * N) % N;
  endfunction

  function automatic int best_of(bit [N-1:0] v, int ptr);
    int best = -1;
    for (int p = 0; p < N; p++)
      if (v[p] && (best < 0 || rank_of(p, ptr) < rank_of(best, ptr))) best = p;
    return best;
  endfunction

  task automatic model_step();
    bit [N-1:0] clr, set, edges;
    int req_w, isr_w, nptr, lvl;
    bit act, i1, i2;
    if (reset) begin
      m_irr = '0; m_isr = '0; m_imr = '0; m_prev = '0;
      m_ptr = N - 1; m_win = 0; m_base = 0; m_spur = 0; m_ltim = 0; m_ic4 = 0;
      m_aeoi = 0; m_rot = 0; m_rdisr = 0; m_ack = 0; m_step = 0;
      e_int = 0; e_vv = 0; e_vec = '0; e_rd = '0;
      return;
    end
    e_vv = 0;
    if (rd_en) e_rd = (addr == 2'd1) ? m_imr : (addr == 2'd0) ? (m_rdisr ? m_isr : m_irr) : '0;
    edges  = irq & ~m_prev;
    m_prev = irq;
    if (wr_en && addr == 2'd0) begin
      m_imr = '0; m_isr = '0; m_irr = '0; m_ptr = N - 1;
      m_ltim = wr_data[3]; m_ic4 = wr_data[0]; m_step = 1; m_ack = 0; e_int = 0;
      return;
    end
    act   = (m_step == 3);
    i1    = inta && act && !m_ack;
    i2    = inta && act && m_ack;
    req_w = best_of(m_irr & ~m_imr, m_ptr);
    isr_w = best_of(m_isr, m_ptr);
    e_int = act && !i1 && req_w >= 0 &&
            (isr_w < 0 || rank_of(req_w, m_ptr) < rank_of(isr_w, m_ptr));
    clr = '0; set = '0; nptr = m_ptr;
    if (i1) begin
      m_ack  = 1;
      m_spur = (req_w < 0);
      m_win  = m_spur ? N - 1 : req_w;
      if (!m_spur) set[req_w] = 1;
    end
    if (m_ltim) m_irr = irq;
    else begin
      if (i1 && req_w >= 0) m_irr[req_w] = 0;
      m_irr |= edges;
    end
    if (i2) begin
      m_ack = 0;
      e_vv  = 1;
      e_vec = 8'(m_base * N + m_win);
      if (m_aeoi && !m_spur) begin
        clr[m_win] = 1;
        if (m_rot) nptr = m_win;
      end
    end
    if (act && wr_en && addr == 2'd2) begin
      lvl = int'(wr_data[ID-1:0]);
      case (wr_data[7:5])
        3'b001: if (isr_w >= 0) clr[isr_w] = 1;
        3'b101: if (isr_w >= 0) begin clr[isr_w] = 1; nptr = isr_w; end
        3'b011: clr[lvl] = 1;
        3'b111: begin clr[lvl] = 1; nptr = lvl; end
        3'b110: nptr = lvl;
        3'b100: m_rot = 1;
        3'b000: m_rot = 0;
        default: ;
      endcase
    end
    m_isr = (m_isr & ~clr) | set;
    m_ptr = nptr;
    if (wr_en && addr == 2'd1) begin
      case (m_step)
        1: begin
             m_base = int'(wr_data >> ID);
             if (m_ic4) m_step = 2;
             else begin m_aeoi = 0; m_step = 3; end
           end
        2: begin m_aeoi = wr_data[1]; m_step = 3; end
        3: m_imr = wr_data;
        default: ;
      endcase
    end
    if (act && wr_en && addr == 2'd3 && wr_data[1]) m_rdisr = wr_data[0];
  endtask

  // ---------------- drivers for the 8-channel DUT ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("int_out", int_out, e_int);
    check("vector_valid", vector_valid, e_vv);
    if (e_vv) check("vector_out", vector_out, e_vec);
    check("rd_data", rd_data, e_rd);
    @(negedge clk);
    wr_en = 0; rd_en = 0; inta = 0; reset = 0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1; addr = a; wr_data = d; tick();
  endtask

  task automatic rd(input logic [1:0] a);
    rd_en = 1; addr = a; tick();
  endtask

  task automatic ack();
    inta = 1; tick();
  endtask

  // ---------------- drivers for the 16-channel DUT ----------------
  task automatic tick16();
    @(posedge clk);
    #1;
    @(negedge clk);
    wr_en16 = 0; rd_en16 = 0; inta16 = 0;
  endtask

  task automatic wr16(input logic [1:0] a, input logic [15:0] d);
    wr_en16 = 1; addr16 = a; wr_data16 = d; tick16();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    reset = 1; tick();
    reset = 1; tick();
    check("rst_int", int_out, 1'b0);
    check("rst_vv", vector_valid, 1'b0);
    check("rst_vec", vector_out, 8'h00);
    check("rst_rd", rd_data, 8'h00);

    // Basic vectoring, edge mode, base 0x40.
    wr(2'd0, 8'h01); wr(2'd1, 8'h40); wr(2'd1, 8'h00);
    irq = 8'h08; tick();
    check("tp1_lat1", int_out, 1'b0);
    tick();
    check("tp1_lat2", int_out, 1'b1);
    ack(); check("tp1_inta1_int", int_out, 1'b0);
    ack(); check("tp1_vv", vector_valid, 1'b1); check("tp1_vec", vector_out, 8'h43);
    wr(2'd3, 8'h0B); rd(2'd0); check("tp1_isr", rd_data, 8'h08);
    wr(2'd3, 8'h0A); rd(2'd0); check("tp1_irr", rd_data, 8'h00);
    irq = 8'h00; wr(2'd2, 8'h20);

    // Masked level 2 loses to level 5.
    wr(2'd1, 8'h04); irq = 8'h24; tick(); tick();
    check("tp2_int", int_out, 1'b1);
    ack(); ack(); check("tp2_vec", vector_out, 8'h45);
    wr(2'd2, 8'h20); wr(2'd3, 8'h0B); rd(2'd0); check("tp2_isr", rd_data, 8'h00);

    // Fully nested behaviour with level 2 in service.
    wr(2'd1, 8'h00); tick();
    check("tp3_unmask_int", int_out, 1'b1);
    ack(); ack(); check("tp3_vec2", vector_out, 8'h42);
    irq = 8'h34; tick(); tick(); tick();
    check("tp3_blocked", int_out, 1'b0);
    irq = 8'h36; tick(); tick();
    check("tp3_nested", int_out, 1'b1);
    ack(); ack(); check("tp3_vec1", vector_out, 8'h41);
    rd(2'd0); check("tp3_isr", rd_data, 8'h06);
    wr(2'd2, 8'h20); tick(); check("tp3_still_blocked", int_out, 1'b0);
    wr(2'd2, 8'h20); tick(); check("tp3_released", int_out, 1'b1);
    ack(); ack(); check("tp3_vec4", vector_out, 8'h44);
    wr(2'd2, 8'h20); irq = 8'h00; tick();

    // AEOI with rotation.
    wr(2'd0, 8'h01); wr(2'd1, 8'h40); wr(2'd1, 8'h02); wr(2'd2, 8'h80);
    irq = 8'h01; tick(); tick();
    ack(); ack(); check("tp4_vec0", vector_out, 8'h40);
    rd(2'd0); check("tp4_isr", rd_data, 8'h00);
    irq = 8'h00; tick();
    irq = 8'h03; tick(); tick();
    ack(); ack(); check("tp4_rot", vector_out, 8'h41);

    // Pending level 0, then spurious, then ICW1 abort during ACK1.
    ack(); ack(); check("tp5_vec0", vector_out, 8'h40);
    irq = 8'h00; tick();
    ack(); ack(); check("tp5_spur", vector_out, 8'h47);
    rd(2'd0); check("tp5_isr", rd_data, 8'h00);
    ack();
    inta = 1; wr(2'd0, 8'h01); check("tp5_abort", vector_valid, 1'b0);
    ack(); check("tp5_no_vec", vector_valid, 1'b0);
    wr(2'd1, 8'h40); rd(2'd1); check("tp5_icw2", rd_data, 8'h00);
    wr(2'd1, 8'h00);

    // Reset in the middle of the handshake.
    irq = 8'h10; tick(); tick(); ack();
    reset = 1; tick();
    ack(); check("tp6_no_vec", vector_valid, 1'b0);
    irq = 8'h00; tick();

    // Randomized traffic.
    wr(2'd0, 8'h01); wr(2'd1, 8'h40); wr(2'd1, 8'h00);
    for (int i = 0; i < 4000; i++) begin
      logic [1:0] a;
      irq = irq ^ N'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 7) == 0) begin
        a = 2'($urandom_range(0, 3));
        if (a == 2'd0 && $urandom_range(0, 15) != 0) a = 2'd2;
        wr_en = 1; addr = a; wr_data = N'($urandom);
      end else if ($urandom_range(0, 3) == 0) begin
        rd_en = 1; addr = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 7) == 0) inta = 1;
      if ($urandom_range(0, 999) == 0) reset = 1;
      tick();
    end

    // 16-channel instance.
    irq16 = '0;
    wr16(2'd0, 16'h0001); wr16(2'd1, 16'h0080); wr16(2'd1, 16'h0000);
    irq16 = 16'h1000; tick16(); tick16();
    check("n16_int", int_out16, 1'b1);
    inta16 = 1; tick16();
    inta16 = 1; tick16();
    check("n16_vv", vector_valid16, 1'b1);
    check("n16_vec", vector_out16, 8'h8C);
    wr16(2'd3, 16'h0003);
    rd_en16 = 1; addr16 = 2'd0; tick16();
    check("n16_isr", rd_data16, 16'h1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
